// File: rtl/hash_table_batch_frontend_pkg.sv
// Package: hash_fe_pkg
// Purpose: Shared types and constants for the hash table batch front end.
//   - opt_t   : write-lane operation encodings
//   - state_t : batching FSM state encoding
//   - ptr_width() plus default pointer widths for the read and write lane pointers
package hash_fe_pkg;

  typedef enum logic [1:0] {
    OPT_NOP = 2'b00,
    OPT_INS = 2'b01,
    OPT_UPD = 2'b10,
    OPT_DEL = 2'b11
  } opt_t;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  // A pointer over n lanes needs $clog2(n) bits. A single-lane pointer
  // still needs one bit, so that case is clamped.
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int NUM_RD_DEF = 16;
  localparam int NUM_WR_DEF = 8;
  localparam int RD_PTR_W   = $clog2(NUM_RD_DEF);
  localparam int WR_PTR_W   = $clog2(NUM_WR_DEF);

endpackage

// File: rtl/hash_table_batch_frontend_xor_reduce_masked.sv
// Module: xor_reduce_masked
// Purpose: Combinational XOR of every lane whose mask bit is set. With an
//   empty mask the result is zero. The parent registers the result.
// Ports:
//   lanes  in   NUM_LANES*DATA_WIDTH   lane i at [i*DATA_WIDTH +: DATA_WIDTH]
//   mask   in   NUM_LANES              1 = lane takes part in the XOR
//   result out  DATA_WIDTH             XOR of the selected lanes
module xor_reduce_masked #(
  parameter int NUM_LANES  = 16,
  parameter int DATA_WIDTH = 64
) (
  input  logic [NUM_LANES*DATA_WIDTH-1:0] lanes,
  input  logic [NUM_LANES-1:0]            mask,
  output logic [DATA_WIDTH-1:0]           result
);

  // Fold the selected lanes into the accumulator. Unselected lanes are
  // skipped, so their contents never reach the result.
  always_comb begin
    result = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (mask[i]) begin
        result = result ^ lanes[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

endmodule

// File: rtl/hash_table_batch_frontend.sv
// Module: hash_table_batch_frontend
// Purpose: Packs a narrow valid/ready stream of read and write beats into one
//   wide batch for the multi-port hash table core. The module issues the batch,
//   waits the fixed core latency, and then returns the XOR of the filled read
//   lanes on a valid/ready result port.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   in_valid/in_ready          input beat handshake (in_ready only in FILL)
//   in_is_wr, in_key,
//   in_value, in_opt, in_last  beat payload; in_last closes the batch
//   core_key/value/opt         lane registers presented to the core
//   core_en                    write-lane enables, only in the issue cycle
//   core_issue                 one-cycle batch issue strobe
//   core_rd_out                core read data, CORE_LATENCY cycles after issue
//   out_valid/out_ready        result handshake
//   out_xor, out_rd_mask       masked XOR result and the read lanes it covers
//   batch_cnt                  completed batches, wraps at 16 bits
module hash_table_batch_frontend
  import hash_fe_pkg::*;
#(
  parameter int NUM_RD       = 16,
  parameter int NUM_WR       = 8,
  parameter int KEY_WIDTH    = 32,
  parameter int VALUE_WIDTH  = 31,
  parameter int DATA_WIDTH   = 64,
  parameter int CORE_LATENCY = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic                          in_is_wr,
  input  logic [KEY_WIDTH-1:0]          in_key,
  input  logic [VALUE_WIDTH-1:0]        in_value,
  input  logic [1:0]                    in_opt,
  input  logic                          in_last,
  output logic [NUM_RD*KEY_WIDTH-1:0]   core_key,
  output logic [NUM_WR*VALUE_WIDTH-1:0] core_value,
  output logic [2*NUM_WR-1:0]           core_opt,
  output logic [NUM_WR-1:0]             core_en,
  output logic                          core_issue,
  input  logic [NUM_RD*DATA_WIDTH-1:0]  core_rd_out,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_WIDTH-1:0]         out_xor,
  output logic [NUM_RD-1:0]             out_rd_mask,
  output logic [15:0]                   batch_cnt
);

  localparam int RPW = ptr_width(NUM_RD);
  localparam int WPW = ptr_width(NUM_WR);
  // The counter must be able to hold CORE_LATENCY itself.
  localparam int CW  = ptr_width(CORE_LATENCY + 1);

  state_t state, state_next;

  logic [RPW-1:0]                  rd_ptr;
  logic [WPW-1:0]                  wr_ptr;
  logic [NUM_RD-1:0]               rd_mask;
  logic [NUM_WR-1:0]               wr_mask;
  logic [NUM_RD*KEY_WIDTH-1:0]     key_lanes;
  logic [NUM_WR*VALUE_WIDTH-1:0]   value_lanes;
  logic [2*NUM_WR-1:0]             opt_lanes;
  logic [CW-1:0]                   lat_cnt;
  logic [DATA_WIDTH-1:0]           out_xor_q;
  logic [NUM_RD-1:0]               out_rd_mask_q;
  logic [15:0]                     batch_cnt_q;
  logic [DATA_WIDTH-1:0]           lane_xor;

  logic beat_fire;
  logic rd_beat;
  logic wr_beat;
  logic rd_last_lane;
  logic wr_last_lane;
  logic close_batch;
  logic lat_expire;
  logic drain_done;

  // Payload inputs only matter when a beat is accepted. Every use of
  // in_is_wr and in_last is gated by beat_fire, so idle-cycle garbage
  // never reaches state.
  assign beat_fire    = in_valid & in_ready;
  assign rd_beat      = beat_fire & ~in_is_wr;
  assign wr_beat      = beat_fire & in_is_wr;
  assign rd_last_lane = (rd_ptr == RPW'(NUM_RD - 1));
  assign wr_last_lane = (wr_ptr == WPW'(NUM_WR - 1));
  assign close_batch  = beat_fire &
                        (in_last | (~in_is_wr & rd_last_lane) | (in_is_wr & wr_last_lane));
  assign lat_expire   = (state == WAIT) && (lat_cnt == CW'(1));
  assign drain_done   = (state == DRAIN) && out_ready;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= FILL;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. A batch only closes on an accepted beat, so every
  // issued batch holds at least one beat.
  always_comb begin
    state_next = state;
    unique case (state)
      FILL:    if (close_batch) state_next = ISSUE;
      ISSUE:   state_next = WAIT;
      WAIT:    if (lat_cnt == CW'(1)) state_next = DRAIN;
      DRAIN:   if (out_ready) state_next = FILL;
      default: state_next = FILL;
    endcase
  end

  // Output decode. The write enables are gated to the issue cycle, so the
  // core sees each write exactly once while the lane data stays up.
  always_comb begin
    in_ready   = 1'b0;
    core_issue = 1'b0;
    core_en    = '0;
    out_valid  = 1'b0;
    unique case (state)
      FILL:    in_ready = 1'b1;
      ISSUE: begin
        core_issue = 1'b1;
        core_en    = wr_mask;
      end
      DRAIN:   out_valid = 1'b1;
      default: ;
    endcase
  end

  // Lane registers, pointers and fill masks. Everything clears when the
  // result is consumed, which is why unfilled lanes present key 0,
  // value 0 and a NOP op at issue time. The lanes hold still through
  // ISSUE and WAIT because in_ready is low there.
  always_ff @(posedge clk) begin
    if (reset || drain_done) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      rd_mask     <= '0;
      wr_mask     <= '0;
      key_lanes   <= '0;
      value_lanes <= '0;
      opt_lanes   <= {NUM_WR{2'(OPT_NOP)}};
    end else begin
      for (int i = 0; i < NUM_RD; i++) begin
        if (rd_beat && (rd_ptr == RPW'(i))) begin
          key_lanes[i*KEY_WIDTH +: KEY_WIDTH] <= in_key;
          rd_mask[i]                          <= 1'b1;
        end
      end
      for (int j = 0; j < NUM_WR; j++) begin
        if (wr_beat && (wr_ptr == WPW'(j))) begin
          value_lanes[j*VALUE_WIDTH +: VALUE_WIDTH] <= in_value;
          opt_lanes[j*2 +: 2]                       <= in_opt;
          wr_mask[j]                                <= 1'b1;
        end
      end
      if (rd_beat) begin
        rd_ptr <= rd_ptr + RPW'(1);
      end
      if (wr_beat) begin
        wr_ptr <= wr_ptr + WPW'(1);
      end
    end
  end

  // Latency counter. It loads in ISSUE and counts down through WAIT. The
  // value 1 marks the CORE_LATENCY-th cycle after issue, which is when
  // core_rd_out is valid. CORE_LATENCY must be at least 1.
  always_ff @(posedge clk) begin
    if (reset) begin
      lat_cnt <= '0;
    end else if (state == ISSUE) begin
      lat_cnt <= CW'(CORE_LATENCY);
    end else if ((state == WAIT) && (lat_cnt != CW'(1))) begin
      lat_cnt <= lat_cnt - CW'(1);
    end
  end

  xor_reduce_masked #(
    .NUM_LANES  (NUM_RD),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_xor_reduce (
    .lanes  (core_rd_out),
    .mask   (rd_mask),
    .result (lane_xor)
  );

  // Result capture. The registers stay frozen from capture until the next
  // capture, so they hold steady through any DRAIN backpressure. A reset
  // during WAIT leaves the FSM in FILL, so the late core data is never
  // captured.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_xor_q     <= '0;
      out_rd_mask_q <= '0;
    end else if (lat_expire) begin
      out_xor_q     <= lane_xor;
      out_rd_mask_q <= rd_mask;
    end
  end

  // Completed-batch counter. It advances on the result handshake and wraps
  // naturally at 16 bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      batch_cnt_q <= '0;
    end else if (drain_done) begin
      batch_cnt_q <= batch_cnt_q + 16'd1;
    end
  end

  assign core_key    = key_lanes;
  assign core_value  = value_lanes;
  assign core_opt    = opt_lanes;
  assign out_xor     = out_xor_q;
  assign out_rd_mask = out_rd_mask_q;
  assign batch_cnt   = batch_cnt_q;

endmodule

// File: tb/tb_hash_table_batch_frontend.sv
// Testbench for hash_table_batch_frontend.
// Three instances share clock and reset and differ in CORE_LATENCY (4, 1, 7).
// A behavioural core model returns key*3 per lane exactly CORE_LATENCY cycles
// after issue and returns junk on every other cycle.
module tb_hash_table_batch_frontend;

  localparam int NI     = 3;
  localparam int NUM_RD = 16;
  localparam int NUM_WR = 8;
  localparam int KW     = 32;
  localparam int VW     = 31;
  localparam int DW     = 64;

  function automatic int lat_of(input int g);
    case (g)
      0:       return 4;
      1:       return 1;
      default: return 7;
    endcase
  endfunction

  typedef struct {
    int          n_rd;
    int          n_wr;
    bit          use_last;
    logic [31:0] key_base;
    logic [30:0] val_base;
    logic [1:0]  opt;
    logic [63:0] exp_xor;
    logic [15:0] exp_mask;
    logic [7:0]  exp_en;
  } batch_vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                   reset;
  logic [NI-1:0]          in_valid, in_ready, in_is_wr, in_last, core_issue, out_valid, out_ready;
  logic [KW-1:0]          in_key      [NI];
  logic [VW-1:0]          in_value    [NI];
  logic [1:0]             in_opt      [NI];
  logic [NUM_RD*KW-1:0]   core_key    [NI];
  logic [NUM_WR*VW-1:0]   core_value  [NI];
  logic [2*NUM_WR-1:0]    core_opt    [NI];
  logic [NUM_WR-1:0]      core_en     [NI];
  logic [NUM_RD*DW-1:0]   core_rd_out [NI];
  logic [DW-1:0]          out_xor     [NI];
  logic [NUM_RD-1:0]      out_rd_mask [NI];
  logic [15:0]            batch_cnt   [NI];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  for (genvar g = 0; g < NI; g++) begin : gen_dut
    hash_table_batch_frontend #(
      .NUM_RD       (NUM_RD),
      .NUM_WR       (NUM_WR),
      .KEY_WIDTH    (KW),
      .VALUE_WIDTH  (VW),
      .DATA_WIDTH   (DW),
      .CORE_LATENCY (lat_of(g))
    ) dut (
      .clk         (clk),
      .reset       (reset),
      .in_valid    (in_valid[g]),
      .in_ready    (in_ready[g]),
      .in_is_wr    (in_is_wr[g]),
      .in_key      (in_key[g]),
      .in_value    (in_value[g]),
      .in_opt      (in_opt[g]),
      .in_last     (in_last[g]),
      .core_key    (core_key[g]),
      .core_value  (core_value[g]),
      .core_opt    (core_opt[g]),
      .core_en     (core_en[g]),
      .core_issue  (core_issue[g]),
      .core_rd_out (core_rd_out[g]),
      .out_valid   (out_valid[g]),
      .out_ready   (out_ready[g]),
      .out_xor     (out_xor[g]),
      .out_rd_mask (out_rd_mask[g]),
      .batch_cnt   (batch_cnt[g])
    );
  end

  // Core model: snapshot keys at issue and present key*3 per lane only in
  // the CORE_LATENCY-th cycle after issue.
  logic [7:0]           pipe     [NI] = '{default: 8'h00};
  logic [NUM_RD*KW-1:0] held_key [NI] = '{default: '0};

  always @(posedge clk) begin
    for (int g = 0; g < NI; g++) begin
      pipe[g] <= {pipe[g][6:0], core_issue[g]};
      if (core_issue[g]) held_key[g] <= core_key[g];
    end
  end

  always_comb begin
    for (int g = 0; g < NI; g++) begin
      for (int i = 0; i < NUM_RD; i++) begin
        core_rd_out[g][i*DW +: DW] = pipe[g][lat_of(g)-1] ?
            (DW'(held_key[g][i*KW +: KW]) * DW'(3)) : ~DW'(i);
      end
    end
  end

  // Issue bookkeeping, sampled mid-cycle.
  int                   issue_count [NI] = '{default: 0};
  int                   en_cycles   [NI] = '{default: 0};
  logic [NUM_WR-1:0]    issue_en    [NI];
  logic [NUM_RD*KW-1:0] issue_key   [NI];
  logic [NUM_WR*VW-1:0] issue_value [NI];
  logic [2*NUM_WR-1:0]  issue_opt   [NI];

  always @(negedge clk) begin
    for (int g = 0; g < NI; g++) begin
      if (core_issue[g]) begin
        issue_count[g] <= issue_count[g] + 1;
        issue_en[g]    <= core_en[g];
        issue_key[g]   <= core_key[g];
        issue_value[g] <= core_value[g];
        issue_opt[g]   <= core_opt[g];
      end
      if (core_en[g] != '0) en_cycles[g] <= en_cycles[g] + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [511:0] actual,
                             input logic [511:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Present one beat and hold it until accepted. t_acc returns the cycle in
  // which the beat was accepted.
  task automatic applyStimulus(input int d, input logic is_wr, input logic [31:0] key,
                               input logic [30:0] value, input logic [1:0] opt,
                               input logic last, output int t_acc);
    int budget;
    budget      = 0;
    in_valid[d] = 1'b1;
    in_is_wr[d] = is_wr;
    in_key[d]   = key;
    in_value[d] = value;
    in_opt[d]   = opt;
    in_last[d]  = last;
    while (!in_ready[d] && budget < 200) begin
      tick();
      budget++;
    end
    t_acc = cyc;
    if (!in_ready[d]) begin
      checks++;
      failures++;
      $display("[TB] FAIL in_ready_timeout dut%0d: got in_ready 0, expected 1", d);
      in_valid[d] = 1'b0;
      return;
    end
    tick();
    in_valid[d] = 1'b0;
    in_is_wr[d] = 1'($urandom);
    in_key[d]   = $urandom;
    in_value[d] = 31'($urandom);
    in_opt[d]   = 2'($urandom);
    in_last[d]  = 1'($urandom);
  endtask

  task automatic waitOut(input int d, input int budget, output int t_valid, output bit ok);
    int n;
    n = 0;
    while (!out_valid[d] && n < budget) begin
      tick();
      n++;
    end
    t_valid = cyc;
    ok      = out_valid[d];
    if (!ok) begin
      checks++;
      failures++;
      $display("[TB] FAIL out_valid_timeout dut%0d: got out_valid 0, expected 1", d);
    end
  endtask

  task automatic doHandshake(input int d);
    out_ready[d] = 1'b1;
    tick();
    out_ready[d] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no completion, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    batch_vec_t vecs [5];
    int t, tv, ic, ec, exp_batches, seen;
    bit ok;
    logic [NUM_RD*KW-1:0] exp_keys;
    logic [NUM_WR*VW-1:0] exp_vals;
    logic [2*NUM_WR-1:0]  exp_opts;

    vecs[0] = '{n_rd:16, n_wr:0, use_last:1'b0, key_base:32'd1, val_base:31'd0, opt:2'b00,
                exp_xor:64'h0, exp_mask:16'hFFFF, exp_en:8'h00};
    vecs[1] = '{n_rd:3, n_wr:1, use_last:1'b1, key_base:32'd1, val_base:31'h5, opt:2'b01,
                exp_xor:64'hC, exp_mask:16'h0007, exp_en:8'h01};
    vecs[2] = '{n_rd:0, n_wr:8, use_last:1'b0, key_base:32'd0, val_base:31'h100, opt:2'b10,
                exp_xor:64'h0, exp_mask:16'h0000, exp_en:8'hFF};
    vecs[3] = '{n_rd:2, n_wr:2, use_last:1'b1, key_base:32'h10, val_base:31'h7FFF0000, opt:2'b11,
                exp_xor:64'h3, exp_mask:16'h0003, exp_en:8'h03};
    vecs[4] = '{n_rd:1, n_wr:0, use_last:1'b1, key_base:32'h80000001, val_base:31'd0, opt:2'b00,
                exp_xor:64'h1_8000_0003, exp_mask:16'h0001, exp_en:8'h00};

    reset     = 1'b1;
    out_ready = '0;
    in_valid  = '0;
    in_is_wr  = '0;
    in_last   = '0;
    for (int g = 0; g < NI; g++) begin
      in_key[g]   = '0;
      in_value[g] = '0;
      in_opt[g]   = '0;
    end
    repeat (3) tick();
    reset = 1'b0;

    $display("[TB] reset state");
    checkOutput("rst_in_ready", 512'(in_ready[0]), 512'(1));
    checkOutput("rst_out_valid", 512'(out_valid), 512'(0));
    checkOutput("rst_core_issue", 512'(core_issue[0]), 512'(0));
    checkOutput("rst_core_en", 512'(core_en[0]), 512'(0));
    checkOutput("rst_core_key", 512'(core_key[0]), 512'(0));
    checkOutput("rst_out_xor", 512'(out_xor[0]), 512'(0));
    checkOutput("rst_out_rd_mask", 512'(out_rd_mask[0]), 512'(0));
    checkOutput("rst_batch_cnt", 512'(batch_cnt[0]), 512'(0));

    $display("[TB] table-driven batches");
    exp_batches = 0;
    for (int v = 0; v < 5; v++) begin
      exp_keys = '0;
      exp_vals = '0;
      exp_opts = '0;
      ic = issue_count[0];
      ec = en_cycles[0];
      t  = cyc;
      for (int i = 0; i < vecs[v].n_rd; i++) begin
        exp_keys[i*KW +: KW] = vecs[v].key_base + 32'(i);
        applyStimulus(0, 1'b0, vecs[v].key_base + 32'(i), 31'($urandom), 2'($urandom),
                      vecs[v].use_last && (vecs[v].n_wr == 0) && (i == vecs[v].n_rd - 1), t);
      end
      for (int j = 0; j < vecs[v].n_wr; j++) begin
        exp_vals[j*VW +: VW] = vecs[v].val_base + 31'(j);
        exp_opts[j*2 +: 2]   = vecs[v].opt;
        applyStimulus(0, 1'b1, $urandom, vecs[v].val_base + 31'(j), vecs[v].opt,
                      vecs[v].use_last && (j == vecs[v].n_wr - 1), t);
      end
      waitOut(0, 40, tv, ok);
      if (ok) begin
        checkOutput($sformatf("v%0d_latency", v), 512'(tv), 512'(t + 2 + 4));
        checkOutput($sformatf("v%0d_out_xor", v), 512'(out_xor[0]), 512'(vecs[v].exp_xor));
        checkOutput($sformatf("v%0d_out_rd_mask", v), 512'(out_rd_mask[0]),
                    512'(vecs[v].exp_mask));
      end
      checkOutput($sformatf("v%0d_issue_count", v), 512'(issue_count[0] - ic), 512'(1));
      checkOutput($sformatf("v%0d_en_cycles", v), 512'(en_cycles[0] - ec),
                  512'((vecs[v].exp_en != 8'h00) ? 1 : 0));
      checkOutput($sformatf("v%0d_core_en", v), 512'(issue_en[0]), 512'(vecs[v].exp_en));
      checkOutput($sformatf("v%0d_core_key", v), 512'(issue_key[0]), 512'(exp_keys));
      checkOutput($sformatf("v%0d_core_value", v), 512'(issue_value[0]), 512'(exp_vals));
      checkOutput($sformatf("v%0d_core_opt", v), 512'(issue_opt[0]), 512'(exp_opts));
      doHandshake(0);
      exp_batches++;
      checkOutput($sformatf("v%0d_batch_cnt", v), 512'(batch_cnt[0]), 512'(exp_batches));
      checkOutput($sformatf("v%0d_in_ready_back", v), 512'(in_ready[0]), 512'(1));
    end

    $display("[TB] DRAIN backpressure");
    applyStimulus(0, 1'b0, 32'd7, 31'd0, 2'd0, 1'b0, t);
    ic = issue_count[0];
    applyStimulus(0, 1'b0, 32'd8, 31'd0, 2'd0, 1'b1, t);
    waitOut(0, 40, tv, ok);
    for (int k = 0; k < 10; k++) begin
      checkOutput("hold_out_valid", 512'(out_valid[0]), 512'(1));
      checkOutput("hold_out_xor", 512'(out_xor[0]), 512'(64'hD));
      checkOutput("hold_out_rd_mask", 512'(out_rd_mask[0]), 512'(16'h0003));
      checkOutput("hold_in_ready", 512'(in_ready[0]), 512'(0));
      tick();
    end
    checkOutput("hold_issue_count", 512'(issue_count[0] - ic), 512'(1));
    doHandshake(0);
    exp_batches++;
    checkOutput("hold_batch_cnt", 512'(batch_cnt[0]), 512'(exp_batches));

    $display("[TB] reset during WAIT");
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 1'b0, 32'(i + 1), 31'd0, 2'd0, 1'(i == 4), t);
    end
    tick();
    tick();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    checkOutput("midrst_in_ready", 512'(in_ready[0]), 512'(1));
    checkOutput("midrst_out_valid", 512'(out_valid[0]), 512'(0));
    checkOutput("midrst_batch_cnt", 512'(batch_cnt[0]), 512'(0));
    checkOutput("midrst_out_xor", 512'(out_xor[0]), 512'(0));
    checkOutput("midrst_core_key", 512'(core_key[0]), 512'(0));
    seen = 0;
    for (int k = 0; k < 12; k++) begin
      if (out_valid[0]) seen++;
      tick();
    end
    checkOutput("midrst_no_out_valid", 512'(seen), 512'(0));
    applyStimulus(0, 1'b0, 32'hA, 31'd0, 2'd0, 1'b1, t);
    waitOut(0, 40, tv, ok);
    if (ok) begin
      checkOutput("midrst_latency", 512'(tv), 512'(t + 6));
      checkOutput("midrst_out_xor_after", 512'(out_xor[0]), 512'(64'h1E));
      checkOutput("midrst_out_rd_mask", 512'(out_rd_mask[0]), 512'(16'h0001));
    end
    doHandshake(0);
    checkOutput("midrst_batch_cnt_after", 512'(batch_cnt[0]), 512'(1));

    $display("[TB] back-to-back batches at CORE_LATENCY 1 and 7");
    for (int d = 1; d < NI; d++) begin
      out_ready[d] = 1'b1;
      for (int b = 0; b < 3; b++) begin
        applyStimulus(d, 1'b0, 32'h20 + 32'(b), 31'd0, 2'd0, 1'b1, t);
        waitOut(d, 40, tv, ok);
        if (ok) begin
          checkOutput($sformatf("b2b_d%0d_b%0d_latency", d, b), 512'(tv),
                      512'(t + 2 + lat_of(d)));
          checkOutput($sformatf("b2b_d%0d_b%0d_out_xor", d, b), 512'(out_xor[d]),
                      512'((64'h20 + 64'(b)) * 64'd3));
        end
        tick();
        checkOutput($sformatf("b2b_d%0d_b%0d_batch_cnt", d, b), 512'(batch_cnt[d]),
                    512'(b + 1));
      end
      out_ready[d] = 1'b0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
